fifo_burst_ctrl: RTL and testbench
==================================

# fifo_burst_ctrl

Sequencing controller for the 8-bit, 1024-word pixel FIFO in the camera path. It accepts a pixel stream and writes it into the FIFO, tracking fill level. When a full burst is available, or a frame flush is requested, it arbitrates for the downstream consumer (SDRAM writer / feature extractor) and drains exactly one burst per grant with a clean valid/last framing. It also counts dropped pixels and sequences FIFO clears.

## Interface
- DATA_W, 8, pixel width; must match the FIFO data width.
- DEPTH, 1024, FIFO depth in words.
- BURST_LEN, 16, words per normal burst; 1..DEPTH.
- LVL_W, 11, level counter width; clog2(DEPTH)+1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream pixel valid; no backpressure.
- in_data  in  DATA_W  upstream pixel.
- in_flush  in  1  1-cycle pulse: end of frame, drain remainder.
- in_clear  in  1  1-cycle pulse: discard FIFO contents.
- fifo_we  out  1  FIFO write enable.
- fifo_di  out  DATA_W  FIFO write data; equals in_data.
- fifo_re  out  1  FIFO read enable.
- fifo_do  in  DATA_W  FIFO read data; valid 1 cycle after fifo_re (NOREG).
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_rst  out  1  synchronous, active-high FIFO reset.
- burst_req  out  1  request for the downstream consumer.
- burst_gnt  in  1  grant; consumer must accept the whole burst without stalls.
- out_valid  out  1  output word valid.
- out_data  out  DATA_W  output word.
- out_last  out  1  last word of each burst.
- out_eof  out  1  last word of a flush burst.
- level  out  LVL_W  words held in the FIFO.
- ovf_cnt  out  16  dropped pixels; saturates at 0xFFFF.
- busy  out  1  high in any state other than IDLE.

## Operation
- Write side: fifo_we = in_valid & ~fifo_full & (state != CLEAR).
  - A pixel offered while fifo_full is high is dropped and increments ovf_cnt.
  - Pixels offered during CLEAR are discarded and are not counted.
- Level: +1 on fifo_we, −1 on fifo_re; unchanged when both occur in the same cycle. Range 0..DEPTH.
- flush_pend: set by in_flush. Cleared when the flush burst completes, or in IDLE when level==0; in that case no burst is issued and out_eof is not emitted.
- States:
  - IDLE → WAIT_GNT when level ≥ BURST_LEN or (flush_pend & level > 0).
  - WAIT_GNT: burst_req=1. When burst_gnt is sampled high, latch blen and go to READ.
    - blen = BURST_LEN if level ≥ BURST_LEN.
    - Otherwise (flush case) blen = level and is_flush is set.
    - If level ≥ BURST_LEN under flush_pend, a normal burst is issued and flush_pend remains set.
  - READ: fifo_re = 1 & ~fifo_empty for blen consecutive cycles, counted by rd_cnt. After the last read go to TAIL.
  - TAIL: 1 cycle while the final word emerges, then IDLE.
  - CLEAR: entered from any state on in_clear, which takes priority over all other events.
    - fifo_rst=1 for 2 cycles.
    - level, ovf_cnt, flush_pend and rd_cnt are zeroed.
    - burst_req and out_valid are forced 0; an in-flight burst is aborted with no out_last.
    - Exits to IDLE.
- Output: out_valid is fifo_re registered by one cycle; out_data = fifo_do; out_last on word blen.
- out_eof = out_last & is_flush; is_flush clears on exit from TAIL.
- The level counter is authoritative for issuing reads. fifo_empty is a safety gate only: if fifo_re is blocked by it, rd_cnt still advances.

## Timing
- Reset values:
  - Registers: state=IDLE; level=0, ovf_cnt=0, flush_pend=0, is_flush=0.
  - Combinational outputs with registered state: fifo_rst=0, burst_req=0, fifo_re=0, out_valid=0, out_last=0, out_eof=0, busy=0.
  - Combinational passthroughs: fifo_we=in_valid & ~fifo_full and fifo_di=in_data (write-path gating above still applies).
- The write that brings level to BURST_LEN makes burst_req rise 2 edges later: level updates at edge e, IDLE→WAIT_GNT at edge e+1.
- If burst_gnt is sampled at edge k:
  - burst_req falls after edge k.
  - fifo_re is high during cycles k..k+blen−1.
  - out_valid is high during cycles k+1..k+blen.
  - out_last is in cycle k+blen; the state is IDLE after edge k+blen+1.
- burst_gnt is ignored outside WAIT_GNT.
- Back-to-back bursts have at least 2 idle cycles between out_last and the next burst_req.
- in_clear asserted during cycle c: fifo_rst is high during cycles c+1 and c+2; IDLE from c+3.

## Test plan
- Write 16 pixels 0x00..0x0F, then grant immediately → burst_req rises; 16 out_valid cycles carry 0x00..0x0F; out_last on 0x0F; out_eof=0; level returns to 0.
- Write 5 pixels, pulse in_flush, grant → blen=5; out_last=out_eof=1 on the 5th word; flush_pend clears. A flush with level=0 produces no burst_req.
- Write 1030 pixels with no grant → level saturates at 1024; ovf_cnt=6; fifo_we never high while fifo_full.
- Continuous in_valid during a 16-word burst → level is unchanged on simultaneous read/write cycles; data order is preserved across the bursts.
- in_clear in the 8th read cycle → out_valid drops; no out_last; fifo_rst high for 2 cycles; level=0 and ovf_cnt=0; the next 16 writes produce a correct burst.
- rst_n pulsed low mid-burst, asynchronously → all outputs reach their reset values immediately.

Source files
------------

// File: rtl/fifo_burst_ctrl.sv
// Burst sequencer for the camera-path pixel FIFO: writes the incoming stream,
// tracks fill level, and drains one framed burst per downstream grant.
module fifo_burst_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 1024,
  parameter int BURST_LEN = 16,
  parameter int LVL_W     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_flush,
  input  logic              in_clear,
  output logic              fifo_we,
  output logic [DATA_W-1:0] fifo_di,
  output logic              fifo_re,
  input  logic [DATA_W-1:0] fifo_do,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  output logic              fifo_rst,
  output logic              burst_req,
  input  logic              burst_gnt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_eof,
  output logic [LVL_W-1:0]  level,
  output logic [15:0]       ovf_cnt,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_GNT, S_READ, S_TAIL, S_CLEAR
  } state_t;

  localparam logic [LVL_W-1:0] ONE     = LVL_W'(1);
  localparam logic [LVL_W-1:0] BURST   = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  state_t             r_state, w_state_next;
  logic [LVL_W-1:0]   r_level, r_rd_cnt, r_blen;
  logic [15:0]        r_ovf_cnt;
  logic               r_flush_pend, r_is_flush;
  logic               r_out_valid, r_out_last;
  logic               r_clr_cnt, r_cool;
  logic               w_inc, w_rd_last, w_start, w_grant;

  assign fifo_we   = in_valid & ~fifo_full & (r_state != S_CLEAR);
  assign fifo_di   = in_data;
  assign fifo_re   = (r_state == S_READ) & ~fifo_empty;
  assign fifo_rst  = (r_state == S_CLEAR);
  assign burst_req = (r_state == S_WAIT_GNT);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = fifo_do;
  assign out_last  = r_out_last;
  assign out_eof   = r_out_last & r_is_flush;
  assign level     = r_level;
  assign ovf_cnt   = r_ovf_cnt;

  // Level clamp keeps the counter inside 0..DEPTH even if fifo_full glitches.
  assign w_inc     = fifo_we & (r_level != DEPTH_L);
  assign w_rd_last = (r_state == S_READ) && (r_rd_cnt == r_blen - ONE);
  assign w_grant   = (r_state == S_WAIT_GNT) & burst_gnt;
  // r_cool holds off one IDLE cycle so consecutive bursts keep a 2-cycle gap.
  assign w_start   = ~r_cool & ((r_level >= BURST) |
                                (r_flush_pend & (r_level != '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch forms.
    w_state_next = r_state;
    if (in_clear) begin
      w_state_next = S_CLEAR;
    end else begin
      case (r_state)
        S_IDLE:     if (w_start)   w_state_next = S_WAIT_GNT;
        S_WAIT_GNT: if (burst_gnt) w_state_next = S_READ;
        S_READ:     if (w_rd_last) w_state_next = S_TAIL;
        S_TAIL:     w_state_next = S_IDLE;
        S_CLEAR:    if (r_clr_cnt) w_state_next = S_IDLE;
        default:    w_state_next = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level      <= '0;
      r_ovf_cnt    <= '0;
      r_flush_pend <= 1'b0;
      r_is_flush   <= 1'b0;
      r_rd_cnt     <= '0;
      r_blen       <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_clr_cnt    <= 1'b0;
      r_cool       <= 1'b0;
    end else begin
      r_out_valid <= fifo_re & ~in_clear;
      r_out_last  <= w_rd_last & ~in_clear;
      r_cool      <= (r_state == S_TAIL);
      r_clr_cnt   <= ~in_clear & (r_state == S_CLEAR);

      if (in_clear)               r_level <= '0;
      else if (w_inc & ~fifo_re)  r_level <= r_level + ONE;
      else if (fifo_re & ~w_inc)  r_level <= r_level - ONE;

      if (in_clear)
        r_ovf_cnt <= '0;
      else if (in_valid & fifo_full & (r_state != S_CLEAR) & (r_ovf_cnt != 16'hFFFF))
        r_ovf_cnt <= r_ovf_cnt + 16'd1;

      // A new flush request wins over a same-cycle completion of the old one.
      if (in_clear)
        r_flush_pend <= 1'b0;
      else if (in_flush)
        r_flush_pend <= 1'b1;
      else if (((r_state == S_TAIL) & r_is_flush) |
               ((r_state == S_IDLE) & (r_level == '0)))
        r_flush_pend <= 1'b0;

      if (in_clear | w_grant)     r_rd_cnt <= '0;
      else if (r_state == S_READ) r_rd_cnt <= r_rd_cnt + ONE;

      if (in_clear | (r_state == S_TAIL)) begin
        r_is_flush <= 1'b0;
      end else if (w_grant) begin
        r_blen     <= (r_level >= BURST) ? BURST : r_level;
        r_is_flush <= (r_level < BURST);
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Directed bench for fifo_burst_ctrl with a behavioural 1024x8 NOREG FIFO
// attached; each task drives one scenario and checks hand-derived values.
module tb_fifo_burst_ctrl;

  localparam int DATA_W = 8;
  localparam int LVL_W  = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_flush = 1'b0;
  logic              in_clear = 1'b0;
  logic              burst_gnt = 1'b0;
  logic              fifo_we, fifo_re, fifo_rst, fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_di, fifo_do, out_data;
  logic              burst_req, out_valid, out_last, out_eof, busy;
  logic [LVL_W-1:0]  level;
  logic [15:0]       ovf_cnt;

  int total = 0;
  int bad   = 0;
  int we_full_viol = 0;

  always #5 clk = ~clk;

  fifo_burst_ctrl #(.DATA_W(8), .DEPTH(1024), .BURST_LEN(16), .LVL_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_flush(in_flush), .in_clear(in_clear), .fifo_we(fifo_we),
    .fifo_di(fifo_di), .fifo_re(fifo_re), .fifo_do(fifo_do),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_rst(fifo_rst),
    .burst_req(burst_req), .burst_gnt(burst_gnt), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_eof(out_eof),
    .level(level), .ovf_cnt(ovf_cnt), .busy(busy)
  );

  // Behavioural FIFO: read data appears on fifo_do one edge after fifo_re.
  logic [DATA_W-1:0] mem [0:1023];
  int m_wp, m_rp, m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || fifo_rst) begin
      m_wp <= 0; m_rp <= 0; m_cnt <= 0; fifo_do <= '0;
    end else begin
      if (fifo_we && m_cnt < 1024) begin
        mem[m_wp] <= fifo_di;
        m_wp <= (m_wp + 1) % 1024;
      end
      if (fifo_re && m_cnt > 0) begin
        fifo_do <= mem[m_rp];
        m_rp <= (m_rp + 1) % 1024;
      end
      m_cnt <= m_cnt + ((fifo_we && m_cnt < 1024) ? 1 : 0) - ((fifo_re && m_cnt > 0) ? 1 : 0);
    end
  end
  assign fifo_empty = (m_cnt == 0);
  assign fifo_full  = (m_cnt == 1024);

  always begin
    @(negedge clk); #2;
    if (rst_n && fifo_we && fifo_full) we_full_viol++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA5;
    #1;
    total++;
    if ({burst_req, fifo_re, out_valid, out_last, out_eof, busy, fifo_rst} !== 7'b0) begin
      bad++; $display("FAIL reset_ctl got=%b exp=0000000",
        {burst_req, fifo_re, out_valid, out_last, out_eof, busy, fifo_rst});
    end
    total++;
    if (level !== 11'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++;
    if (ovf_cnt !== 16'd0) begin bad++; $display("FAIL reset_ovf got=%0d exp=0", ovf_cnt); end
    total++;
    if (fifo_we !== 1'b1) begin bad++; $display("FAIL reset_we got=%b exp=1", fifo_we); end
    total++;
    if (fifo_di !== 8'hA5) begin bad++; $display("FAIL reset_di got=%h exp=a5", fifo_di); end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Writes n words from base, optionally flushes, grants at once and checks
  // the cycle-exact framing of the resulting burst.
  task automatic do_burst(input logic [7:0] base, input int n, input bit flush, input string tag);
    logic exp_re, exp_v, exp_l, exp_e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = base + 8'(i);
    end
    @(negedge clk); in_valid = 1'b0;
    total++;
    if (level !== 11'(n)) begin bad++; $display("FAIL %s_level got=%0d exp=%0d", tag, level, n); end
    total++;
    if (burst_req !== 1'b0) begin bad++; $display("FAIL %s_req_early got=%b exp=0", tag, burst_req); end
    if (flush) begin
      in_flush = 1'b1;
      @(negedge clk); in_flush = 1'b0;
      total++;
      if (burst_req !== 1'b0) begin bad++; $display("FAIL %s_req_flush got=%b exp=0", tag, burst_req); end
    end
    @(negedge clk);
    total++;
    if (burst_req !== 1'b1) begin bad++; $display("FAIL %s_req_rise got=%b exp=1", tag, burst_req); end
    burst_gnt = 1'b1;
    @(negedge clk); burst_gnt = 1'b0;
    for (int i = 0; i <= n + 1; i++) begin
      if (i > 0) @(negedge clk);
      exp_re = (i < n);
      exp_v  = (i >= 1) && (i <= n);
      exp_l  = (i == n);
      exp_e  = exp_l & flush;
      total++;
      if ({burst_req, fifo_re, out_valid, out_last, out_eof} !== {1'b0, exp_re, exp_v, exp_l, exp_e}) begin
        bad++; $display("FAIL %s_frame[%0d] req/re/v/last/eof got=%b exp=%b", tag, i,
          {burst_req, fifo_re, out_valid, out_last, out_eof}, {1'b0, exp_re, exp_v, exp_l, exp_e});
      end
      if (exp_v) begin
        total++;
        if (out_data !== base + 8'(i - 1)) begin
          bad++; $display("FAIL %s_data[%0d] got=%h exp=%h", tag, i, out_data, base + 8'(i - 1));
        end
      end
    end
    total++;
    if ({busy, level} !== {1'b0, 11'd0}) begin
      bad++; $display("FAIL %s_end busy=%b level=%0d exp busy=0 level=0", tag, busy, level);
    end
  endtask

  task automatic test_burst();
    do_burst(8'h00, 16, 1'b0, "burst16");
  endtask

  task automatic test_flush();
    int seen;
    do_burst(8'h20, 5, 1'b1, "flush5");
    @(negedge clk); in_flush = 1'b1;
    @(negedge clk); in_flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (burst_req || busy) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL flush_empty_req got=%0d cycles exp=0", seen); end
    // Three words must sit idle: a stale flush request would drain them.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'h30 + 8'(i);
    end
    @(negedge clk); in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (burst_req) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL flush_pend_stale got=%0d cycles exp=0", seen); end
    total++;
    if (level !== 11'd3) begin bad++; $display("FAIL flush_hold_level got=%0d exp=3", level); end
    in_clear = 1'b1;
    @(negedge clk); in_clear = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 1030; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'(i);
    end
    @(negedge clk); in_valid = 1'b0;
    total++;
    if (level !== 11'd1024) begin bad++; $display("FAIL ovf_level got=%0d exp=1024", level); end
    total++;
    if (ovf_cnt !== 16'd6) begin bad++; $display("FAIL ovf_cnt got=%0d exp=6", ovf_cnt); end
    total++;
    if (we_full_viol != 0) begin bad++; $display("FAIL ovf_we_when_full got=%0d exp=0", we_full_viol); end
    total++;
    if (burst_req !== 1'b1) begin bad++; $display("FAIL ovf_req got=%b exp=1", burst_req); end
    in_clear = 1'b1;
    @(negedge clk); in_clear = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, level, ovf_cnt} !== {1'b0, 11'd0, 16'd0}) begin
      bad++; $display("FAIL ovf_clear busy=%b level=%0d ovf=%0d exp 0/0/0", busy, level, ovf_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx [$];
    int written = 0, rule_err = 0, gap_err = 0, sim_rw = 0, last_cnt = 0, eof_cnt = 0;
    int last_cyc = -100, data_err = 0, exp_lvl;
    logic prev_we = 1'b0, prev_re = 1'b0;
    logic [LVL_W-1:0] prev_level = '0;
    for (int c = 0; c < 240; c++) begin
      @(negedge clk);
      if (c > 0) begin
        exp_lvl = int'(prev_level) + int'(prev_we) - int'(prev_re);
        if (int'(level) != exp_lvl) rule_err++;
      end
      if (out_valid) rx.push_back(out_data);
      if (out_last) begin last_cyc = c; last_cnt++; end
      if (out_eof) eof_cnt++;
      if (burst_req && (c - last_cyc) < 3) gap_err++;
      in_valid  = (c < 100);
      in_data   = 8'(written);
      if (in_valid) written++;
      in_flush  = (c == 120);
      burst_gnt = burst_req;
      #1;
      prev_we = fifo_we; prev_re = fifo_re; prev_level = level;
      if (fifo_we && fifo_re) sim_rw++;
    end
    in_valid = 1'b0; in_flush = 1'b0; burst_gnt = 1'b0;
    total++;
    if (rx.size() != 100) begin bad++; $display("FAIL b2b_count got=%0d exp=100", rx.size()); end
    foreach (rx[j]) if (rx[j] !== 8'(j)) data_err++;
    total++;
    if (data_err != 0) begin bad++; $display("FAIL b2b_order got=%0d errors exp=0", data_err); end
    total++;
    if (rule_err != 0) begin bad++; $display("FAIL b2b_level_rule got=%0d errors exp=0", rule_err); end
    total++;
    if (sim_rw == 0) begin bad++; $display("FAIL b2b_overlap got=0 exp=>0"); end
    total++;
    if (gap_err != 0) begin bad++; $display("FAIL b2b_gap got=%0d errors exp=0", gap_err); end
    total++;
    if (last_cnt != 7) begin bad++; $display("FAIL b2b_lasts got=%0d exp=7", last_cnt); end
    total++;
    if (eof_cnt != 1) begin bad++; $display("FAIL b2b_eof got=%0d exp=1", eof_cnt); end
    total++;
    if ({busy, level} !== {1'b0, 11'd0}) begin
      bad++; $display("FAIL b2b_end busy=%b level=%0d exp 0/0", busy, level);
    end
  endtask

  task automatic test_clear_mid_burst();
    logic [7:0] rx [$];
    int last_seen = 0, data_err = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'h40 + 8'(i);
    end
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); burst_gnt = 1'b1;
    @(negedge clk); burst_gnt = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (out_valid) rx.push_back(out_data);
      if (out_last) last_seen++;
    end
    in_clear = 1'b1;
    @(negedge clk); in_clear = 1'b0;
    if (out_last) last_seen++;
    total++;
    if ({out_valid, fifo_rst} !== 2'b01) begin
      bad++; $display("FAIL clr_c1 valid/rst got=%b exp=01", {out_valid, fifo_rst});
    end
    @(negedge clk);
    if (out_last) last_seen++;
    total++;
    if ({out_valid, fifo_rst, burst_req} !== 3'b010) begin
      bad++; $display("FAIL clr_c2 valid/rst/req got=%b exp=010", {out_valid, fifo_rst, burst_req});
    end
    @(negedge clk);
    total++;
    if ({fifo_rst, busy, level, ovf_cnt} !== {1'b0, 1'b0, 11'd0, 16'd0}) begin
      bad++; $display("FAIL clr_c3 rst=%b busy=%b level=%0d ovf=%0d exp 0/0/0/0",
        fifo_rst, busy, level, ovf_cnt);
    end
    total++;
    if (rx.size() != 7) begin bad++; $display("FAIL clr_words got=%0d exp=7", rx.size()); end
    foreach (rx[j]) if (rx[j] !== 8'h40 + 8'(j)) data_err++;
    total++;
    if (data_err != 0) begin bad++; $display("FAIL clr_data got=%0d errors exp=0", data_err); end
    total++;
    if (last_seen != 0) begin bad++; $display("FAIL clr_no_last got=%0d exp=0", last_seen); end
    do_burst(8'h50, 16, 1'b0, "post_clear");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'h60 + 8'(i);
    end
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); burst_gnt = 1'b1;
    @(negedge clk); burst_gnt = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, busy} !== 2'b11) begin
      bad++; $display("FAIL arst_pre valid/busy got=%b exp=11", {out_valid, busy});
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({fifo_we, fifo_re, fifo_rst, burst_req, out_valid, out_last, out_eof, busy} !== 8'b0) begin
      bad++; $display("FAIL arst_ctl got=%b exp=00000000",
        {fifo_we, fifo_re, fifo_rst, burst_req, out_valid, out_last, out_eof, busy});
    end
    total++;
    if ({level, ovf_cnt} !== {11'd0, 16'd0}) begin
      bad++; $display("FAIL arst_cnt level=%0d ovf=%0d exp 0/0", level, ovf_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, level} !== {1'b0, 11'd0}) begin
      bad++; $display("FAIL arst_after busy=%b level=%0d exp 0/0", busy, level);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_flush();
    test_overflow();
    test_back_to_back();
    test_clear_mid_burst();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
